// File: rtl/keypad_scanner_if.sv
// Keypad pad-side and key-event signals; master = scanner, slave = keypad/consumer side.
// Rows come in active-low from the pads; key events are registered outputs.
interface keypad_scanner_if;
    logic [3:0] i_row;
    logic [3:0] o_col;
    logic [3:0] o_key_code;
    logic       o_key_valid;
    logic       o_key_pulse;

    modport master (
        input  i_row,
        output o_col,
        output o_key_code,
        output o_key_valid,
        output o_key_pulse
    );

    modport slave (
        output i_row,
        input  o_col,
        input  o_key_code,
        input  o_key_valid,
        input  o_key_pulse
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with frame-level debounce; KEYPAD_AUTOREPEAT_EN adds repeat pulses.
// Latency: outputs update the cycle after the frame end that decides them; no backpressure (pulse is a strobe).
// Rows pass a 2-FF synchroniser; multi-key frames are rejected as ghosts.
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 50
) (
    input  logic             i_clk,
    input  logic             i_rst,
    keypad_scanner_if.master kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    // Nibble i is the code of key index row*4+col.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    if (SCAN_DIV < 4) begin : g_chk_div
        $error("SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_FRAMES < 2) begin : g_chk_deb
        $error("DEBOUNCE_FRAMES must be at least 2");
    end
    if (REPEAT_FRAMES < 1) begin : g_chk_rep
        $error("REPEAT_FRAMES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_NONE,
        S_PRESS_PEND,
        S_HELD,
        S_RELEASE_PEND
    } state_t;

    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_sync;
    logic [DW-1:0] r_dwell;
    logic [3:0]    r_col;
    logic [1:0]    r_col_idx;
    logic [15:0]   r_frame;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cand;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_key_pulse;

    logic          w_dwell_last;
    logic          w_frame_end;
    logic [15:0]   w_frame;
    logic [4:0]    w_ones;
    logic [3:0]    w_idx;
    logic          w_single;
    logic [3:0]    w_code;
    logic [CW-1:0] w_cnt_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] REP_DONE = RW'(REPEAT_FRAMES);
    logic [RW-1:0] r_rep;
    logic [RW-1:0] w_rep_inc;
    assign w_rep_inc = r_rep + 1'b1;
`endif

    assign w_dwell_last = (r_dwell == DWELL_LAST);
    assign w_frame_end  = w_dwell_last && (r_col_idx == 2'd3);
    assign w_cnt_inc    = (r_cnt >= CNT_DONE) ? CNT_DONE : r_cnt + 1'b1;

    // Frame as it will look once the current column's sample lands, so the
    // frame-end decision sees column 3 in the same cycle.
    always_comb begin
        w_frame = r_frame;
        for (int r = 0; r < 4; r++) begin
            w_frame[{r[1:0], r_col_idx}] = ~r_row_sync[r];
        end
    end

    always_comb begin
        w_ones = 5'd0;
        w_idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame[i]) begin
                w_ones = w_ones + 5'd1;
                w_idx  = 4'(i);
            end
        end
    end

    assign w_single = (w_ones == 5'd1);
    assign w_code   = KEY_MAP[{w_idx, 2'b00} +: 4];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row_meta  <= 4'hF;
            r_row_sync  <= 4'hF;
            r_dwell     <= '0;
            r_col       <= 4'b1110;
            r_col_idx   <= 2'd0;
            r_frame     <= '0;
            r_state     <= S_NONE;
            r_cnt       <= '0;
            r_cand      <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_pulse <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_row_meta  <= kp.i_row;
            r_row_sync  <= r_row_meta;
            r_key_pulse <= 1'b0;

            if (w_dwell_last) begin
                r_dwell   <= '0;
                r_col     <= {r_col[2:0], r_col[3]};
                r_col_idx <= r_col_idx + 2'd1;
                r_frame   <= w_frame;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end

            if (w_frame_end) begin
                case (r_state)
                    S_NONE: begin
                        if (w_single) begin
                            r_cand  <= w_code;
                            r_cnt   <= CNT_ONE;
                            r_state <= S_PRESS_PEND;
                        end
                    end
                    S_PRESS_PEND: begin
                        if (w_single && (w_code == r_cand)) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_DONE) begin
                                r_state     <= S_HELD;
                                r_cnt       <= '0;
                                r_key_code  <= r_cand;
                                r_key_valid <= 1'b1;
                                r_key_pulse <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                                r_rep       <= '0;
`endif
                            end
                        end else if (w_single) begin
                            r_cand <= w_code;
                            r_cnt  <= CNT_ONE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_NONE;
                        end
                    end
                    S_HELD: begin
                        if (w_single && (w_code == r_key_code)) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (w_rep_inc == REP_DONE) begin
                                r_rep       <= '0;
                                r_key_pulse <= 1'b1;
                            end else begin
                                r_rep <= w_rep_inc;
                            end
`endif
                        end else begin
                            r_state <= S_RELEASE_PEND;
                            r_cnt   <= CNT_ONE;
`ifdef KEYPAD_AUTOREPEAT_EN
                            r_rep   <= '0;
`endif
                        end
                    end
                    S_RELEASE_PEND: begin
                        if (w_single && (w_code == r_key_code)) begin
                            // Bounce back: key never really left, so no new pulse.
                            r_state <= S_HELD;
                            r_cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            r_rep   <= '0;
`endif
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_DONE) begin
                                r_state     <= S_NONE;
                                r_cnt       <= '0;
                                r_key_valid <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_NONE;
                endcase
            end
        end
    end

    assign kp.o_col       = r_col;
    assign kp.o_key_code  = r_key_code;
    assign kp.o_key_valid = r_key_valid;
    assign kp.o_key_pulse = r_key_pulse;
endmodule
